inst_fetch_wb_bridge: RTL
=========================

# inst_fetch_wb_bridge

Parametrised instruction-fetch bridge between the openmips fetch port (ce/addr/data) and a Wishbone classic master port. It replaces the direct ROM hookup in the SOPC, so instruction memory can live behind wb_conmax with arbitrary wait states. The bridge holds the last fetched word in a one-entry buffer and stalls the pipeline on a miss. It also supports pipeline flush, bus-error reporting and a bus timeout.

## Interface
- ADDR_W, 32: fetch/Wishbone address width
- DATA_W, 32: instruction width, multiple of 8
- TIMEOUT, 255: cycles without ack/err before the bus cycle is abandoned, range 1..65535
- NOP_INST, 32'h0: word returned to the CPU on bus error or timeout

Ports:
- clk  in  1  single clock domain
- rst  in  1  synchronous, active-high reset
- rom_ce_i  in  1  fetch enable from the CPU
- rom_addr_i  in  ADDR_W  fetch address
- flush_i  in  1  pipeline flush; invalidates the buffered and in-flight fetch
- rom_data_o  out  DATA_W  instruction to the CPU
- stallreq_o  out  1  stall request to the pipeline controller
- bus_err_o  out  1  one-cycle pulse on wb_err_i or timeout
- wb_adr_o  out  ADDR_W
- wb_dat_i  in  DATA_W
- wb_sel_o  out  DATA_W/8  constant all-ones
- wb_we_o  out  1  constant 0
- wb_cyc_o, wb_stb_o  out  1  driven identically
- wb_ack_i, wb_err_i  in  1

## Operation
- Buffer registers:
  - hold_valid
  - hold_addr
  - hold_data
- Hit condition: rom_ce_i && hold_valid && rom_addr_i == hold_addr && !flush_i.
- States:
  - IDLE
  - BUS
  - DRAIN
- IDLE:
  - rom_ce_i=0: rom_data_o=0, stallreq_o=0.
  - Hit: rom_data_o=hold_data, stallreq_o=0. Both are combinational.
  - Miss with rom_ce_i=1 and flush_i=0: stallreq_o=1 combinationally. On the next edge, wb_adr_o<=rom_addr_i, cyc/stb<=1, the timeout counter clears, and the state moves to BUS.
- BUS: stallreq_o=1 whenever rom_ce_i=1.
  - wb_ack_i: hold_addr<=wb_adr_o, hold_data<=wb_dat_i, hold_valid<=1, cyc/stb<=0, go to IDLE.
  - wb_err_i, or counter == TIMEOUT−1 with no ack: hold_addr<=wb_adr_o, hold_data<=NOP_INST, hold_valid<=1, bus_err_o<=1 for one cycle, cyc/stb<=0, go to IDLE.
  - flush_i without ack/err: hold_valid<=0, go to DRAIN. cyc/stb stay asserted.
- DRAIN: the cycle runs to ack, err or timeout. The result is discarded and hold_valid stays 0. err or timeout still pulses bus_err_o. Then go to IDLE.
- Priority within one cycle: ack/err > timeout > flush. If flush_i and ack arrive in the same BUS cycle, the data is captured, then hold_valid<=0.
- flush_i in IDLE: hold_valid<=0. No bus cycle starts that cycle.
- Address change during BUS (only under a protocol violation): the completing fetch is still buffered, and the new address misses on return to IDLE.
- The timeout counter is ceil(log2(TIMEOUT+1)) bits wide and saturates. No wrap is permitted.

## Timing
- Reset values:
  - All outputs 0, except wb_sel_o which is all-ones.
  - State IDLE, hold_valid=0, counter=0.
- Reset mid-cycle drops cyc/stb on the next edge with no handshake.
- Miss latency with a zero-wait slave (ack in the first stb cycle):
  - stallreq_o high for exactly 2 cycles.
  - Data is presented without stall in cycle 3.
  - Each slave wait state adds one cycle.
- Back-to-back sequential fetches each miss. Throughput is one instruction per 3 cycles with a zero-wait slave.
- bus_err_o is registered and asserts the cycle after err/timeout detection.

## Structure
- Add to defines.v:
  - State encodings IFB_IDLE / IFB_BUS / IFB_DRAIN
  - NOP word (ZeroWord)
  - WB select all-ones constant
- Single module. No sub-module is justified; the buffer and counter are a few registers each.

## Test plan
- Zero-wait slave, rom_addr_i=0x0000_0000 → 0x0000_0004, memory words 0x3401_1100 / 0x3402_0020: stall 2 cycles per fetch, correct words delivered, wb_adr_o matches each address.
- Slave with 3 wait states, repeated fetch of 0x0000_0010 held across 4 cycles: exactly one bus cycle; stall 5 cycles, then hits with no further cyc.
- flush_i pulsed in the 2nd BUS cycle of fetch 0x20: cyc held until ack, data discarded, hold_valid=0, fetch of 0x20 re-issued afterwards.
- wb_err_i on fetch 0x40: bus_err_o one-cycle pulse, rom_data_o=NOP_INST, stall released, no retry.
- TIMEOUT=4, slave never acks: cyc/stb drop after 4 BUS cycles, bus_err_o pulses, NOP returned.
- rst asserted while cyc=1: cyc/stb/stallreq_o=0 next edge, hold_valid=0, first post-reset fetch misses.

Source files
------------

// File: rtl/inst_fetch_wb_bridge_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_wb_bridge_pkg
//
// Shared definitions for the instruction-fetch Wishbone bridge:
//   - ifb_state_e : bridge FSM encoding (IFB_IDLE / IFB_BUS / IFB_DRAIN)
//   - ZERO_WORD   : all-zero instruction word (default NOP on bus failure)
//   - cnt_width() : width of the saturating timeout counter
// ---------------------------------------------------------------------------
package inst_fetch_wb_bridge_pkg;

  // IFB_IDLE  : no bus cycle open; hits are served from the one-entry buffer.
  // IFB_BUS   : bus cycle open for a fetch whose result will be buffered.
  // IFB_DRAIN : bus cycle open for a fetch that was flushed; its result is
  //             dropped but the Wishbone handshake must still complete.
  typedef enum logic [1:0] {
    IFB_IDLE  = 2'd0,
    IFB_BUS   = 2'd1,
    IFB_DRAIN = 2'd2
  } ifb_state_e;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // ceil(log2(timeout+1)): just enough bits to hold the value TIMEOUT,
  // so the counter can reach TIMEOUT-1 and saturate without wrapping.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/inst_fetch_wb_bridge.sv
// ---------------------------------------------------------------------------
// inst_fetch_wb_bridge
//
// Bridges the openmips instruction-fetch port (ce/addr/data + stall request)
// to a Wishbone classic master port. The last fetched word is kept in a
// one-entry buffer; a fetch that does not match it stalls the pipeline
// while a single Wishbone read is performed. Bus errors and timeouts return
// NOP_INST to the CPU and pulse bus_err_o. A pipeline flush invalidates the
// buffer and turns any open bus cycle into a drain whose data is discarded.
//
// Parameters:
//   ADDR_W   fetch / Wishbone address width
//   DATA_W   instruction width (multiple of 8)
//   TIMEOUT  bus cycles without ack/err before the cycle is abandoned
//   NOP_INST word handed to the CPU after a bus error or timeout
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rom_ce_i          fetch enable from the CPU
//   rom_addr_i        fetch address
//   flush_i           pipeline flush
//   rom_data_o        instruction to the CPU (combinational on a hit)
//   stallreq_o        stall request to the pipeline controller
//   bus_err_o         registered one-cycle pulse on err or timeout
//   wb_adr_o..wb_we_o Wishbone classic master outputs
//   wb_dat_i, wb_ack_i, wb_err_i  Wishbone slave responses
//   dbg_state         current FSM state, for observation only
//
// Handshake: a Wishbone transfer is open while wb_cyc_o/wb_stb_o are high;
// it completes in the first clock in which the slave raises wb_ack_i or
// wb_err_i (ack wins if both are high). cyc/stb fall on the following edge.
// On the CPU side, rom_data_o is valid in any cycle with rom_ce_i=1 and
// stallreq_o=0.
// ---------------------------------------------------------------------------
module inst_fetch_wb_bridge
  import inst_fetch_wb_bridge_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(ZERO_WORD)
) (
  input  logic                clk,
  input  logic                rst,
  // CPU fetch port
  input  logic                rom_ce_i,
  input  logic [ADDR_W-1:0]   rom_addr_i,
  input  logic                flush_i,
  output logic [DATA_W-1:0]   rom_data_o,
  output logic                stallreq_o,
  output logic                bus_err_o,
  // Wishbone classic master
  output logic [ADDR_W-1:0]   wb_adr_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_we_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  // observation
  output ifb_state_e          dbg_state
);

  localparam int              CNT_W   = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  ifb_state_e          state;
  ifb_state_e          state_next;

  logic                hold_valid;
  logic [ADDR_W-1:0]   hold_addr;
  logic [DATA_W-1:0]   hold_data;

  logic                cyc_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [CNT_W-1:0]    tmo_cnt;
  logic                bus_err_q;

  // -------------------------------------------------------------------------
  // Control decode
  // -------------------------------------------------------------------------
  logic                hit;
  logic                timeout_hit;
  logic                bus_end;    // open cycle terminates this clock
  logic                bus_fail;   // ...and terminates without data

  logic                start_fetch;
  logic                bus_done;
  logic                capture;
  logic                err_set;
  logic                stall;
  logic [DATA_W-1:0]   data_out;

  assign hit         = rom_ce_i && hold_valid && (rom_addr_i == hold_addr) && !flush_i;
  assign timeout_hit = (tmo_cnt == TO_LAST);
  assign bus_end     = wb_ack_i || wb_err_i || timeout_hit;
  // ack has priority over both err and timeout.
  assign bus_fail    = !wb_ack_i && (wb_err_i || timeout_hit);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IFB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and control outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    start_fetch = 1'b0;
    bus_done    = 1'b0;
    capture     = 1'b0;
    err_set     = 1'b0;
    stall       = 1'b0;
    data_out    = '0;

    case (state)
      IFB_IDLE: begin
        if (hit) begin
          data_out = hold_data;
        end
        // A flush in IDLE only invalidates; the CPU re-presents the fetch
        // after the flush, so no bus cycle is opened for it.
        if (rom_ce_i && !hit && !flush_i) begin
          stall       = 1'b1;
          start_fetch = 1'b1;
          state_next  = IFB_BUS;
        end
      end

      IFB_BUS: begin
        stall = rom_ce_i;
        if (bus_end) begin
          // Completion outranks a simultaneous flush: the word is still
          // captured, only its valid bit is suppressed.
          bus_done   = 1'b1;
          capture    = 1'b1;
          err_set    = bus_fail;
          state_next = IFB_IDLE;
        end else if (flush_i) begin
          state_next = IFB_DRAIN;
        end
      end

      IFB_DRAIN: begin
        stall = rom_ce_i;
        if (bus_end) begin
          bus_done   = 1'b1;
          err_set    = bus_fail;
          state_next = IFB_IDLE;
        end
      end

      default: begin
        state_next = IFB_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: Wishbone master registers, timeout counter, fetch buffer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
      cyc_q      <= 1'b0;
      adr_q      <= '0;
      tmo_cnt    <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      bus_err_q <= err_set;

      if (start_fetch) begin
        adr_q   <= rom_addr_i;
        cyc_q   <= 1'b1;
        tmo_cnt <= '0;
      end else if (bus_done) begin
        cyc_q   <= 1'b0;
      end else if (cyc_q && (tmo_cnt != CNT_MAX)) begin
        // Saturating: the count never wraps back below TO_LAST.
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end

      // The buffer is tagged with the address actually sent on the bus, so
      // an address change mid-cycle simply misses when IDLE is re-entered.
      if (capture) begin
        hold_addr  <= adr_q;
        hold_data  <= bus_fail ? NOP_INST : wb_dat_i;
        hold_valid <= !flush_i;
      end else if (flush_i) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign rom_data_o = data_out;
  assign stallreq_o = stall;
  assign bus_err_o  = bus_err_q;

  assign wb_adr_o   = adr_q;
  assign wb_sel_o   = '1;
  assign wb_we_o    = 1'b0;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;

  assign dbg_state  = state;

endmodule
